puf_host_engine: RTL

Synthesizable host-side frame engine for the PUF SoC. It buffers challenge words in an internal FIFO and, on command, issues a start pulse with an operating mode. It then streams one challenge frame over the SoC receive valid/ready channel and collects the response frame from the SoC transmit channel. It is a parametrised successor to the testbench-only host stimulus. It sits directly on the SoC rx/tx ports, so the same traffic can run in silicon, on FPGA or in simulation.

---
 rtl/puf_host_engine.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/puf_host_engine.sv
// Host-side PUF frame engine: challenge FIFO, start/mode handshake, rx frame streaming, tx response capture.
// Optional stall watchdog compiled in with PUF_HOST_TIMEOUT_EN.
module puf_host_engine #(
  parameter int DATA_W     = 8,
  parameter int FRAM_SIZE  = 4,
  parameter int RSP_SIZE   = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16,
  parameter int TO_CYC     = 1024
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              cmd_go,
  input  logic              cfg_op_mode,
  output logic              o_start,
  output logic              o_op_mode,
  input  logic              i_rx_ready,
  output logic              o_rx_valid,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_tx_ready,
  input  logic              i_tx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  frame_cnt
);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WCW = $clog2(FRAM_SIZE + 1);
  localparam int RCW = $clog2(RSP_SIZE + 1);

  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  FRAM_C  = CW'(FRAM_SIZE);
  localparam logic [WCW-1:0] WLAST   = WCW'(FRAM_SIZE - 1);
  localparam logic [RCW-1:0] RLAST   = RCW'(RSP_SIZE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [WCW-1:0]    wcnt;
  logic [RCW-1:0]    rcnt;
  logic              push, rx_hs, tx_hs, go_ok, abort;

  assign ld_ready   = (cnt != DEPTH_C);
  assign push       = ld_valid && ld_ready;
  assign o_start    = (state == S_START);
  assign o_rx_valid = (state == S_SEND);
  assign o_tx_ready = (state == S_WAIT);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign o_rx_data  = o_rx_valid ? mem[rd_ptr] : '0;
  assign rx_hs      = o_rx_valid && i_rx_ready;
  assign tx_hs      = o_tx_ready && i_tx_valid;
  assign go_ok      = (state == S_IDLE) && cmd_go && (cnt >= FRAM_C);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ld_data;
  end

  // An abort flushes the FIFO together with the frame it was feeding.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (rx_hs) rd_ptr <= rd_ptr + 1'b1;
      case ({push, rx_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      o_op_mode <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      frame_cnt <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (go_ok) begin
            state     <= S_START;
            o_op_mode <= cfg_op_mode;
            wcnt      <= '0;
            rcnt      <= '0;
          end
          S_START: state <= S_SEND;
          S_SEND: if (rx_hs) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == WLAST) state <= S_WAIT;
          end
          S_WAIT: if (tx_hs) begin
            rsp_data  <= i_tx_data;
            rsp_valid <= 1'b1;
            rcnt      <= rcnt + 1'b1;
            if (rcnt == RLAST) state <= S_DONE;
          end
          S_DONE: begin
            frame_cnt <= frame_cnt + 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PUF_HOST_TIMEOUT_EN
  localparam int SW = $clog2(TO_CYC + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TO_CYC - 1);

  logic [SW-1:0] stall;
  logic          stalling, to_q;

  // Any cycle that is not a stalled SEND/WAIT_RSP cycle restarts the count.
  assign stalling = (o_rx_valid && !i_rx_ready) || (o_tx_ready && !i_tx_valid);
  assign abort    = stalling && (stall == STALL_LAST);
  assign timeout  = to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall <= '0;
      to_q  <= 1'b0;
    end else begin
      if (go_ok)      to_q <= 1'b0;
      else if (abort) to_q <= 1'b1;
      stall <= stalling ? stall + 1'b1 : '0;
    end
  end
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0 & (TO_CYC == 0);
`endif

endmodule
